// File: rtl/vga_capture_if.sv
// Pixel-receive / capture-write bundle for vga_capture.
// master: the capture block (samples pixels, drives the write stream).
// slave : the environment (drives pixels, sinks the write stream).
interface vga_capture_if #(
   parameter int unsigned AW = 14
);
   logic          vga_hsync;
   logic          vga_vsync;
   logic          vga_blank_n;
   logic [7:0]    vga_r;
   logic [7:0]    vga_g;
   logic [7:0]    vga_b;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [23:0]   wr_data;

   modport master (
      input  vga_hsync, vga_vsync, vga_blank_n, vga_r, vga_g, vga_b,
      output wr_en, wr_addr, wr_data
   );

   modport slave (
      output vga_hsync, vga_vsync, vga_blank_n, vga_r, vga_g, vga_b,
      input  wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/vga_capture.sv
// vga_capture: recovers pixel coordinates from a blank/vsync pixel stream and
// writes one WIN_W x WIN_H window of one frame as a linear write stream.
// Optional feature macro: VGA_CAPTURE_CONTINUOUS_EN (capture every frame
// after the first arm instead of single-shot).
module vga_capture #(
   parameter int unsigned H_SIZE = 640,
   parameter int unsigned V_SIZE = 480,
   parameter int unsigned WIN_W  = 100,
   parameter int unsigned WIN_H  = 100,
   parameter int unsigned WIN_X  = (H_SIZE - WIN_W) / 2,
   parameter int unsigned WIN_Y  = (V_SIZE - WIN_H) / 2,
   parameter int unsigned AW     = $clog2(WIN_W) + $clog2(WIN_H)
) (
   input  logic           clk,
   input  logic           rst,
   vga_capture_if.master  bus,
   input  logic           arm,
   output logic           busy,
   output logic           done,
   output logic           err
);
   localparam int unsigned XW    = $clog2(H_SIZE);
   localparam int unsigned YW    = $clog2(V_SIZE);
   localparam int unsigned X_END = WIN_X + WIN_W;
   localparam int unsigned Y_END = WIN_Y + WIN_H;
   localparam logic [XW-1:0] X_MAX     = XW'(H_SIZE - 1);
   localparam logic [YW-1:0] Y_MAX     = YW'(V_SIZE - 1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(WIN_W * WIN_H - 1);

   typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE, DONE} state_e;

   state_e        state_q, state_d;
   logic          s1_vsync_q, s1_vsync_d, s1_blank_q, s1_blank_d;
   logic          s2_vsync_q, s2_vsync_d, s2_blank_q, s2_blank_d;
   logic          s1_arm_q, s1_arm_d;
   logic [23:0]   s1_rgb_q, s1_rgb_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic          wr_en_q, wr_en_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [23:0]   wr_data_q, wr_data_d;
   logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic          vs_fall, blank_fall, in_win, last_wr;
   logic          unused_hsync;

   // hsync carries nothing beyond what blank_n already gives for coordinates
   assign unused_hsync = bus.vga_hsync;

   assign vs_fall    = s2_vsync_q & ~s1_vsync_q;
   assign blank_fall = s2_blank_q & ~s1_blank_q;
   assign in_win     = s1_blank_q
                     && (32'(x_q) >= WIN_X) && (32'(x_q) < X_END)
                     && (32'(y_q) >= WIN_Y) && (32'(y_q) < Y_END);
   assign last_wr    = in_win && (ptr_q == LAST_ADDR);

   // Input stage, edge-detect copies and saturating coordinate counters
   always_comb begin
      s1_vsync_d = bus.vga_vsync;
      s1_blank_d = bus.vga_blank_n;
      s1_rgb_d   = {bus.vga_r, bus.vga_g, bus.vga_b};
      s1_arm_d   = arm;
      s2_vsync_d = s1_vsync_q;
      s2_blank_d = s1_blank_q;
      x_d = x_q;
      y_d = y_q;
      if (blank_fall)                   x_d = '0;
      else if (s1_blank_q && x_q != X_MAX) x_d = x_q + 1'b1;
      if (vs_fall)                      y_d = '0;
      else if (blank_fall && y_q != Y_MAX) y_d = y_q + 1'b1;
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_vsync_q <= 1'b1;
         s1_blank_q <= 1'b0;
         s2_vsync_q <= 1'b1;
         s2_blank_q <= 1'b0;
         s1_arm_q   <= 1'b0;
         s1_rgb_q   <= '0;
         x_q        <= '0;
         y_q        <= '0;
      end else begin
         s1_vsync_q <= s1_vsync_d;
         s1_blank_q <= s1_blank_d;
         s2_vsync_q <= s2_vsync_d;
         s2_blank_q <= s2_blank_d;
         s1_arm_q   <= s1_arm_d;
         s1_rgb_q   <= s1_rgb_d;
         x_q        <= x_d;
         y_q        <= y_d;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:       if (s1_arm_q) state_d = WAIT_FRAME;
         WAIT_FRAME: if (vs_fall)  state_d = CAPTURE;
         CAPTURE: begin
            if (last_wr) state_d = DONE;
`ifdef VGA_CAPTURE_CONTINUOUS_EN
            else if (vs_fall) state_d = CAPTURE;
`else
            else if (vs_fall) state_d = IDLE;
`endif
         end
`ifdef VGA_CAPTURE_CONTINUOUS_EN
         DONE:       state_d = WAIT_FRAME;
`else
         DONE:       state_d = IDLE;
`endif
         default:    state_d = IDLE;
      endcase
   end

   // FSM outputs: write stream, address pointer and status flags
   always_comb begin
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      ptr_d     = ptr_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (s1_arm_q) begin
               busy_d = 1'b1;
               err_d  = 1'b0;
            end
         end
         WAIT_FRAME: begin
            busy_d = 1'b1;
            if (vs_fall) begin
               ptr_d     = '0;
               wr_addr_d = '0;
            end
         end
         CAPTURE: begin
            if (in_win) begin
               wr_en_d   = 1'b1;
               wr_addr_d = ptr_q;
               wr_data_d = s1_rgb_q;
               ptr_d     = ptr_q + 1'b1;
            end else if (vs_fall) begin
               err_d = 1'b1;
`ifdef VGA_CAPTURE_CONTINUOUS_EN
               // the cutting vsync is also the start of the next frame
               ptr_d     = '0;
               wr_addr_d = '0;
`else
               busy_d = 1'b0;
`endif
            end
         end
         DONE: begin
            done_d = 1'b1;
`ifdef VGA_CAPTURE_CONTINUOUS_EN
            busy_d = 1'b1;
`else
            busy_d = 1'b0;
`endif
         end
         default: ;
      endcase
   end

   // Output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         ptr_q     <= ptr_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a reduced 64x48 raster with a 12x10 window.
// Pixel RGB = {x[7:0], y[7:0], 8'hA5}; window writes are scoreboarded.
module tb_vga_capture;
   localparam int H    = 64;
   localparam int V    = 48;
   localparam int WW   = 12;
   localparam int WH   = 10;
   localparam int WX   = (H - WW) / 2;   // 26
   localparam int WY   = (V - WH) / 2;   // 19
   localparam int AW   = $clog2(WW) + $clog2(WH);
   localparam int NPIX = WW * WH;        // 120
   localparam int HBL  = 6;
`ifdef VGA_CAPTURE_CONTINUOUS_EN
   localparam bit CONT = 1'b1;
`else
   localparam bit CONT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, arm, busy, done, err;

   vga_capture_if #(.AW(AW)) bus ();

   vga_capture #(
      .H_SIZE(H), .V_SIZE(V), .WIN_W(WW), .WIN_H(WH), .AW(AW)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .arm(arm),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [23:0]   data;
      int            cyc;
   } wr_t;

   typedef struct {
      int lines;
      bit arm_mid;
      int exp_wr;
      int exp_done;
      bit exp_err;
   } vec_t;

   wr_t exp_q[$];
   int  n_tests = 0, n_fail = 0;
   int  n_wr = 0, n_done = 0, n_nz = 0, cyc = 0, mdl_addr = 0;
   bit  expect_cap = 1'b0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   function automatic void monitor();
      wr_t e;
      if (bus.wr_en) begin
         n_wr++;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: addr %0d data %06h, no write required", bus.wr_addr, bus.wr_data);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
            chk("wr_data", 32'(bus.wr_data), 32'(e.data));
            chk("wr_latency", cyc, e.cyc);
         end
      end
      if (done) n_done++;
      if (bus.wr_en || busy || done || err || bus.wr_addr != '0 || bus.wr_data != '0) n_nz++;
   endfunction

   task automatic tick();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      monitor();
   endtask

   task automatic drive_line(input int y, input bit act, input bit vs, input bit arm_first,
                             input bit arm_mid, input int rst_y, input int rst_x);
      wr_t e;
      for (int i = 0; i < HBL; i++) begin
         bus.vga_vsync   = vs;
         bus.vga_hsync   = !(i >= 1 && i < 4);
         bus.vga_blank_n = 1'b0;
         bus.vga_r = 8'h00; bus.vga_g = 8'h00; bus.vga_b = 8'h00;
         arm = (i == 0) && (arm_first || (arm_mid && act && y == WY + 2));
         tick();
      end
      arm = 1'b0;
      for (int x = 0; x < H; x++) begin
         if (act && y == rst_y && x == rst_x) begin
            rst = 1'b0;
            exp_q.delete();
            expect_cap = 1'b0;
         end
         bus.vga_hsync   = 1'b1;
         bus.vga_vsync   = vs;
         bus.vga_blank_n = act;
         bus.vga_r = act ? 8'(x) : 8'h00;
         bus.vga_g = act ? 8'(y) : 8'h00;
         bus.vga_b = act ? 8'hA5 : 8'h00;
         if (act && expect_cap && x >= WX && x < WX + WW && y >= WY && y < WY + WH && mdl_addr < NPIX) begin
            e.addr = AW'(mdl_addr);
            e.data = {8'(x), 8'(y), 8'hA5};
            e.cyc  = cyc + 2;
            exp_q.push_back(e);
            mdl_addr++;
         end
         tick();
      end
      if (act && y == rst_y) rst = 1'b1;
   endtask

   // two vsync lines, one back-porch line, nlines active lines, one blank line
   task automatic drive_frame(input int nlines, input bit arm_at_vs, input bit arm_mid,
                              input int rst_y, input int rst_x);
      if (expect_cap) mdl_addr = 0;
      drive_line(0, 1'b0, 1'b0, arm_at_vs, 1'b0, -1, -1);
      drive_line(0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
      drive_line(0, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1);
      for (int y = 0; y < nlines; y++) drive_line(y, 1'b1, 1'b1, 1'b0, arm_mid, rst_y, rst_x);
      drive_line(0, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1);
   endtask

   task automatic arm_pulse(input string tag);
      bus.vga_vsync = 1'b1; bus.vga_blank_n = 1'b0;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      tick();
      chk({tag, "_busy_after_arm"}, busy, 1);
      chk({tag, "_err_cleared_by_arm"}, err, 0);
   endtask

   task automatic check_end(input string tag, input int exp_wr, input int exp_done,
                            input bit exp_err, input bit exp_busy);
      chk({tag, "_queue_drained"}, exp_q.size(), 0);
      chk({tag, "_write_count"}, n_wr, exp_wr);
      chk({tag, "_done_count"}, n_done, exp_done);
      chk({tag, "_err"}, err, exp_err);
      chk({tag, "_busy"}, busy, exp_busy);
   endtask

   task automatic run_capture(input string tag, input int lines, input bit arm_mid,
                              input int exp_wr, input int exp_done, input bit exp_err, input bit exp_busy);
      arm_pulse(tag);
      n_wr = 0; n_done = 0;
      expect_cap = 1'b1;
      drive_frame(lines, 1'b0, arm_mid, -1, -1);
      expect_cap = 1'b0;
      drive_frame(0, 1'b0, 1'b0, -1, -1);
      check_end(tag, exp_wr, exp_done, exp_err, exp_busy);
   endtask

   initial begin
      vec_t tbl[6];
      tbl[0] = '{V,       1'b0, NPIX,          1, 1'b0};  // full frame
      tbl[1] = '{26,      1'b0, 7 * WW,        0, 1'b1};  // cut after line 25
      tbl[2] = '{V,       1'b1, NPIX,          1, 1'b0};  // extra arm while busy
      tbl[3] = '{WY + WH, 1'b0, NPIX,          1, 1'b0};  // frame ends right after last window line
      tbl[4] = '{WY + WH - 1, 1'b0, (WH - 1) * WW, 0, 1'b1};  // one window line short
      tbl[5] = '{WY + 1,  1'b0, WW,            0, 1'b1};  // only first window line

      rst = 1'b0; arm = 1'b0;
      bus.vga_hsync = 1'b1; bus.vga_vsync = 1'b1; bus.vga_blank_n = 1'b0;
      bus.vga_r = 8'h00; bus.vga_g = 8'h00; bus.vga_b = 8'h00;

      // reset values, then a whole frame (with an arm) under reset
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_wr_en", bus.wr_en, 0);
      chk("rst_wr_addr", 32'(bus.wr_addr), 0);
      chk("rst_wr_data", bus.wr_data, 0);
      n_nz = 0; n_wr = 0;
      drive_frame(V, 1'b0, 1'b1, -1, -1);
      chk("rst_frame_nonzero_outputs", n_nz, 0);
      chk("rst_frame_writes", n_wr, 0);
      rst = 1'b1;
      tick();
      run_capture("post_reset", V, 1'b0, NPIX, 1, 1'b0, CONT);

`ifdef VGA_CAPTURE_CONTINUOUS_EN
      rst = 1'b0; tick(); rst = 1'b1; tick();
      arm_pulse("cont");
      n_wr = 0; n_done = 0;
      expect_cap = 1'b1;
      for (int f = 0; f < 3; f++) drive_frame(V, 1'b0, 1'b0, -1, -1);
      expect_cap = 1'b0;
      drive_frame(0, 1'b0, 1'b0, -1, -1);
      check_end("cont", 3 * NPIX, 3, 1'b0, 1'b1);
`else
      for (int i = 0; i < 6; i++)
         run_capture($sformatf("vec%0d", i), tbl[i].lines, tbl[i].arm_mid,
                     tbl[i].exp_wr, tbl[i].exp_done, tbl[i].exp_err, 1'b0);

      // arm on the same cycle as the vsync falling edge: that frame is skipped
      n_wr = 0; n_done = 0;
      expect_cap = 1'b0;
      drive_frame(V, 1'b1, 1'b0, -1, -1);
      chk("coinc_busy_after_skipped_frame", busy, 1);
      chk("coinc_err_cleared", err, 0);
      chk("coinc_no_writes_first_frame", n_wr, 0);
      expect_cap = 1'b1;
      drive_frame(V, 1'b0, 1'b0, -1, -1);
      expect_cap = 1'b0;
      drive_frame(0, 1'b0, 1'b0, -1, -1);
      check_end("coinc", NPIX, 1, 1'b0, 1'b0);

      // asynchronous reset in the middle of window line WY+3 at column WX+4
      arm_pulse("midrst");
      n_wr = 0; n_done = 0;
      expect_cap = 1'b1;
      drive_frame(V, 1'b0, 1'b0, WY + 3, WX + 4);
      expect_cap = 1'b0;
      drive_frame(0, 1'b0, 1'b0, -1, -1);
      check_end("midrst", 3 * WW + 3, 0, 1'b0, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
